// File: rtl/pipTypes.sv
// rtl/pipTypes.sv - shared pipeline types for decode and issue stages
package pipTypes;

    localparam int ISSUE_WIDTH  = 2;
    localparam int INSERT_WIDTH = 4;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_inst_t;

    typedef struct packed {
        dec_inst_t   inst;
        logic [10:0] tag;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction queue between decode and issue
module inst_queue
    import pipTypes::*;
#(
    parameter int IQ_DEPTHLOG2 = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                flush,
    input  logic                                ins_enable,
    input  logic                                ins_valid,
    input  logic [1:0]                          new_count,
    input  iq_entry_t [INSERT_WIDTH-1:0]        new_elements,
    output logic                                iq_full,
    output iq_entry_t [ISSUE_WIDTH-1:0]         out_elements,
    output logic [ISSUE_WIDTH-1:0]              out_valid,
    input  logic [1:0]                          deq_count,
    output logic [IQ_DEPTHLOG2:0]               occupancy
);

    localparam int                DEPTH   = 1 << IQ_DEPTHLOG2;
    localparam logic [IQ_DEPTHLOG2:0] DEPTH_W = (IQ_DEPTHLOG2 + 1)'(DEPTH);

    iq_entry_t                storage [DEPTH];
    logic [IQ_DEPTHLOG2-1:0]  head;
    logic [IQ_DEPTHLOG2-1:0]  tail;
    logic [IQ_DEPTHLOG2:0]    count;

    logic [IQ_DEPTHLOG2:0]    free_slots;
    logic                     do_ins;
    logic [2:0]               ins_num;
    logic [1:0]               num_valid;
    logic [1:0]               deq_eff;

    always_comb begin
        free_slots = DEPTH_W - count;
        iq_full    = free_slots < (IQ_DEPTHLOG2 + 1)'(INSERT_WIDTH);
        do_ins     = ins_enable & ins_valid & ~iq_full & ~flush;
        ins_num    = {1'b0, new_count} + 3'd1;
        num_valid  = (count > (IQ_DEPTHLOG2 + 1)'(1)) ? 2'd2 : count[1:0];
        // Over-large dequeue requests are clamped so head never passes tail.
        deq_eff    = (deq_count > num_valid) ? num_valid : deq_count;
    end

    always_comb begin
        out_elements = '0;
        out_valid    = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            out_elements[k] = storage[head + IQ_DEPTHLOG2'(k)];
            out_valid[k]    = count > (IQ_DEPTHLOG2 + 1)'(k);
        end
    end

    assign occupancy = count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + IQ_DEPTHLOG2'(deq_eff);
            if (do_ins) begin
                tail <= tail + IQ_DEPTHLOG2'(ins_num);
            end
            count <= count + (do_ins ? (IQ_DEPTHLOG2 + 1)'(ins_num) : '0)
                           - (IQ_DEPTHLOG2 + 1)'(deq_eff);
        end
    end

    // Storage carries no reset; slot indices wrap naturally past DEPTH-1.
    always_ff @(posedge clock) begin
        if (do_ins && reset_n) begin
            for (int k = 0; k < INSERT_WIDTH; k++) begin
                if (2'(k) <= new_count) begin
                    storage[tail + IQ_DEPTHLOG2'(k)] <= new_elements[k];
                end
            end
        end
    end

    deq_legal_a: assert property (@(posedge clock) disable iff (!reset_n)
        !flush |-> (deq_count <= num_valid));

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - randomized scoreboard bench for inst_queue
module tb_inst_queue;
    import pipTypes::*;

    localparam int DEPTH = 16;

    typedef struct {
        logic      v0;
        logic      v1;
        iq_entry_t e0;
        iq_entry_t e1;
        int        occ;
        logic      full;
    } snap_t;

    logic                         clock = 1'b0;
    logic                         reset_n = 1'b0;
    logic                         flush = 1'b0;
    logic                         ins_enable = 1'b0;
    logic                         ins_valid = 1'b0;
    logic [1:0]                   new_count = '0;
    iq_entry_t [INSERT_WIDTH-1:0] new_elements = '0;
    logic                         iq_full;
    iq_entry_t [ISSUE_WIDTH-1:0]  out_elements;
    logic [ISSUE_WIDTH-1:0]       out_valid;
    logic [1:0]                   deq_count = '0;
    logic [4:0]                   occupancy;

    int        checks = 0;
    int        failures = 0;
    iq_entry_t model_q[$];
    snap_t     exp_q[$];
    iq_entry_t stim_e [4];

    inst_queue #(.IQ_DEPTHLOG2(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .ins_enable   (ins_enable),
        .ins_valid    (ins_valid),
        .new_count    (new_count),
        .new_elements (new_elements),
        .iq_full      (iq_full),
        .out_elements (out_elements),
        .out_valid    (out_valid),
        .deq_count    (deq_count),
        .occupancy    (occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.v0   = model_q.size() > 0;
        s.v1   = model_q.size() > 1;
        s.e0   = s.v0 ? model_q[0] : '0;
        s.e1   = s.v1 ? model_q[1] : '0;
        s.occ  = model_q.size();
        s.full = (DEPTH - model_q.size()) < 4;
        return s;
    endfunction

    task automatic set_entries(input logic [7:0] base);
        for (int k = 0; k < 4; k++) begin
            stim_e[k] = iq_entry_t'({base + 8'(k), 24'($urandom)});
        end
    endtask

    task automatic drive(input logic fl, input logic en, input logic vl,
                         input logic [1:0] nc, input logic [1:0] dq);
        logic was_full;
        @(negedge clock);
        flush      = fl;
        ins_enable = en;
        ins_valid  = vl;
        new_count  = nc;
        deq_count  = dq;
        for (int k = 0; k < 4; k++) new_elements[k] = stim_e[k];
        was_full = (DEPTH - model_q.size()) < 4;
        if (fl) begin
            model_q.delete();
        end else begin
            for (int i = 0; i < int'(dq); i++) void'(model_q.pop_front());
            if (en && vl && !was_full) begin
                for (int k = 0; k <= int'(nc); k++) model_q.push_back(stim_e[k]);
            end
        end
        exp_q.push_back(model_snap());
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    // Scoreboard monitor: each expectation describes the state after the next edge.
    initial begin
        snap_t s;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("occupancy", 32'(occupancy), 32'(s.occ));
                check("iq_full", 32'(iq_full), 32'(s.full));
                check("out_valid", 32'(out_valid), {30'b0, s.v1, s.v0});
                if (s.v0) check("out_elem0", out_elements[0], s.e0);
                if (s.v1) check("out_elem1", out_elements[1], s.e1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        iq_entry_t ea, eb;
        #1;
        check("reset_occ", 32'(occupancy), 32'd0);
        check("reset_full", 32'(iq_full), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Four entries A-D appear one cycle later.
        set_entries(8'hA0);
        ea = stim_e[0];
        eb = stim_e[1];
        drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        after_edge();
        check("first_a", out_elements[0], ea);
        check("first_b", out_elements[1], eb);
        check("first_occ", 32'(occupancy), 32'd4);

        // Fill to 13, then a further insert must be ignored.
        set_entries(8'hB0); drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        set_entries(8'hB4); drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        set_entries(8'hB8); drive(1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
        after_edge();
        check("fill_full", 32'(iq_full), 32'd1);
        set_entries(8'hBC); drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        after_edge();
        check("full_ignored", 32'(occupancy), 32'd13);
        set_entries(8'hC0); drive(1'b0, 1'b1, 1'b0, 2'd3, 2'd0);

        // Flush together with insert and dequeue at count 9.
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        set_entries(8'hC4); drive(1'b1, 1'b1, 1'b1, 2'd3, 2'd2);
        after_edge();
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);

        // Move head and tail to 14, then insert across the wrap point.
        for (int i = 0; i < 3; i++) begin
            set_entries(8'(8'h10 + 4 * i)); drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        end
        set_entries(8'h1C); drive(1'b0, 1'b1, 1'b1, 2'd1, 2'd0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        set_entries(8'hE0);
        drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        after_edge();
        check("wrap_empty", 32'(occupancy), 32'd0);

        // Insert 2 and dequeue 2 at count 5.
        set_entries(8'h30); drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        set_entries(8'h34); drive(1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
        set_entries(8'h38); drive(1'b0, 1'b1, 1'b1, 2'd1, 2'd2);
        after_edge();
        check("ins_deq_occ", 32'(occupancy), 32'd5);

        // Insert and dequeue at count DEPTH-4.
        set_entries(8'h40); drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd0);
        set_entries(8'h44); drive(1'b0, 1'b1, 1'b1, 2'd2, 2'd0);
        set_entries(8'h48); drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd2);
        after_edge();
        check("edge_occ", 32'(occupancy), 32'd14);

        // Reset pulsed in the middle of an insert cycle.
        @(negedge clock);
        set_entries(8'h50);
        ins_enable = 1'b1; ins_valid = 1'b1; new_count = 2'd3; deq_count = 2'd0;
        for (int k = 0; k < 4; k++) new_elements[k] = stim_e[k];
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_occ", 32'(occupancy), 32'd0);
        check("rst_mid_full", 32'(iq_full), 32'd0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        model_q.delete();
        @(negedge clock);
        ins_enable = 1'b0; ins_valid = 1'b0;
        reset_n = 1'b1;
        set_entries(8'h60);
        ea = stim_e[0];
        drive(1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
        after_edge();
        check("post_rst_first", out_elements[0], ea);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            n = model_q.size();
            set_entries(8'($urandom));
            drive(($urandom_range(0, 39) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                  2'($urandom), 2'($urandom_range(0, (n > 2) ? 2 : n)));
        end
        idle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
